// File: rtl/top_core_soc.sv
// top_core_soc: SPI-loaded unified memory feeding a single-cycle RV32E-subset CPU; define SPI_READ_EN to enable cmd 0x0B memory reads on spi_sdo0
module top_core_soc #(
  parameter int          MEM_WORDS = 64,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_enable_i,
  input  logic        en_ifetch_i,
  input  logic        spi_sclk,
  input  logic        spi_cs,
  output logic [1:0]  spi_mode,
  input  logic        spi_sdi0,
  input  logic        spi_sdi1,
  input  logic        spi_sdi2,
  input  logic        spi_sdi3,
  output logic        spi_sdo0,
  output logic        spi_sdo1,
  output logic        spi_sdo2,
  output logic        spi_sdo3,
  output logic [31:0] gpio_o
);
  localparam int AW = $clog2(MEM_WORDS);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} spi_st_t;
  logic [31:0] mem [MEM_WORDS];
  logic [2:0]  sclk_q;
  logic [1:0]  cs_q, sdi_q;
  logic        rise, cs, sdi;
  spi_st_t     st;
  logic [5:0]  cnt;
  logic [7:0]  cmd;
  logic [31:0] sh, sh_n, spi_addr;
  logic        spi_we;
  logic [31:0] pc, pc_n, instr, rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] alu_b, alu, ea, ld_v, wb_v;
  logic [31:0] rf [16];
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [3:0]  rd, rs1, rs2;
  logic        run, halted, halt, wb_en, st_en, taken, sub;
  logic        unused_ok;
  assign spi_mode = 2'b00;
  assign spi_sdo1 = 1'b0;
  assign spi_sdo2 = 1'b0;
  assign spi_sdo3 = 1'b0;
  assign rise = sclk_q[1] & ~sclk_q[2];
  assign cs = cs_q[1];
  assign sdi = sdi_q[1];
  assign sh_n = {sh[30:0], sdi};
  // bring the SPI pins into the clk_i domain; sclk keeps a third tap for edge detection
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      sclk_q <= '0;
      cs_q <= 2'b11;
      sdi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_sclk};
      cs_q <= {cs_q[0], spi_cs};
      sdi_q <= {sdi_q[0], spi_sdi0};
    end
  // frame parser: 8b cmd, 32b addr, 32b data; a write pulse fires only on the 72nd bit of cmd 0x02
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      st <= IDLE;
      cnt <= '0;
      cmd <= '0;
      sh <= '0;
      spi_addr <= '0;
      spi_we <= 1'b0;
    end else begin
      spi_we <= 1'b0;
      if (cs) st <= IDLE;
      else if (st == IDLE) begin
        st <= CMD;
        cnt <= '0;
      end else if (rise && st != DONE) begin
        sh <= sh_n;
        cnt <= cnt + 6'd1;
        if (st == CMD && cnt == 6'd7) begin
          st <= ADDR;
          cnt <= '0;
          cmd <= sh_n[7:0];
        end else if (st == ADDR && cnt == 6'd31) begin
          st <= DATA;
          cnt <= '0;
          spi_addr <= sh_n;
        end else if (st == DATA && cnt == 6'd31) begin
          st <= DONE;
          spi_we <= cmd == 8'h02;
        end
      end
    end
`ifdef SPI_READ_EN
  logic        fall;
  logic [31:0] rd_sh;
  assign fall = ~sclk_q[1] & sclk_q[2];
  // read word is captured as the address completes, then one bit leaves on each sclk fall
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rd_sh <= '0;
      spi_sdo0 <= 1'b0;
    end else begin
      if (st == ADDR && rise && cnt == 6'd31) rd_sh <= mem[sh_n[AW+1:2]];
      else if (st == DATA && fall) rd_sh <= {rd_sh[30:0], 1'b0};
      spi_sdo0 <= (st == DATA && cmd == 8'h0B) ? (fall ? rd_sh[31] : spi_sdo0) : 1'b0;
    end
`else
  assign spi_sdo0 = 1'b0;
`endif
  assign run = fetch_enable_i & en_ifetch_i & ~halted;
  assign instr = mem[pc[AW+1:2]];
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign rd = instr[10:7];
  assign rs1 = instr[18:15];
  assign rs2 = instr[23:20];
  assign rs1_v = rf[rs1];
  assign rs2_v = rf[rs2];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign alu_b = op == 7'h33 ? rs2_v : imm_i;
  assign sub = op == 7'h33 && instr[30];
  assign ea = rs1_v + (op == 7'h23 ? imm_s : imm_i);
  assign ld_v = ea[31] ? gpio_o : mem[ea[AW+1:2]];
  assign taken = f3 == 3'b000 ? rs1_v == rs2_v :
                 f3 == 3'b001 ? rs1_v != rs2_v :
                 f3 == 3'b100 ? $signed(rs1_v) < $signed(rs2_v) :
                 f3 == 3'b101 ? $signed(rs1_v) >= $signed(rs2_v) : 1'b0;
  assign unused_ok = &{spi_sdi1, spi_sdi2, spi_sdi3, ea[1:0], ea[30:AW+2], pc[1:0], pc[31:AW+2],
                       spi_addr[1:0], spi_addr[31:AW+2]};
  // shared ALU for register and immediate forms
  always_comb
    case (f3)
      3'b000: alu = sub ? rs1_v - alu_b : rs1_v + alu_b;
      3'b001: alu = rs1_v << alu_b[4:0];
      3'b100: alu = rs1_v ^ alu_b;
      3'b101: alu = rs1_v >> alu_b[4:0];
      3'b110: alu = rs1_v | alu_b;
      default: alu = rs1_v & alu_b;
    endcase
  // decode: writeback, store and next-pc selection; unknown opcodes fall through as NOP
  always_comb begin
    wb_en = 1'b0;
    wb_v = alu;
    st_en = 1'b0;
    halt = 1'b0;
    pc_n = pc + 32'd4;
    case (op)
      7'h37: begin wb_en = 1'b1; wb_v = imm_u; end
      7'h17: begin wb_en = 1'b1; wb_v = pc + imm_u; end
      7'h13, 7'h33: wb_en = f3[2:1] != 2'b01;
      7'h03: begin wb_en = 1'b1; wb_v = ld_v; end
      7'h23: st_en = 1'b1;
      7'h63: pc_n = taken ? pc + imm_b : pc + 32'd4;
      7'h6F: begin wb_en = 1'b1; wb_v = pc + 32'd4; pc_n = pc + imm_j; end
      7'h67: begin wb_en = 1'b1; wb_v = pc + 32'd4; pc_n = (rs1_v + imm_i) & ~32'd1; end
      7'h7F: begin halt = 1'b1; pc_n = pc; end
      default: ;
    endcase
  end
  // architectural state advances only while both enables are high and the core has not halted; x0 is never written
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      pc <= BOOT_ADDR;
      halted <= 1'b0;
      gpio_o <= '0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (run) begin
      pc <= pc_n;
      halted <= halt;
      if (wb_en && rd != 4'd0) rf[rd] <= wb_v;
      if (st_en && ea[31]) gpio_o <= rs2_v;
    end
  // memory is not reset; the SPI write is applied last so it wins a same-word collision
  always_ff @(posedge clk_i) begin
    if (run && st_en && !ea[31]) mem[ea[AW+1:2]] <= rs2_v;
    if (spi_we) mem[spi_addr[AW+1:2]] <= sh;
  end
endmodule

// File: tb/tb_top_core_soc.sv
// tb_top_core_soc: scoreboard bench loading programs over SPI and checking GPIO stores against arithmetic expectations
module tb_top_core_soc;
  logic clk = 1'b0, rst = 1'b1, fe = 1'b0, ie = 1'b0, sclk = 1'b0, cs = 1'b1, sdi0 = 1'b0;
  logic [1:0] spi_mode;
  logic sdo0, sdo1, sdo2, sdo3;
  logic [31:0] gpio, last = '0;
  logic [31:0] expq[$];
  logic [31:0] prog[$];
  int tests = 0, fails = 0;

  top_core_soc dut (
    .clk_i(clk), .rst_i(rst), .fetch_enable_i(fe), .en_ifetch_i(ie),
    .spi_sclk(sclk), .spi_cs(cs), .spi_mode(spi_mode),
    .spi_sdi0(sdi0), .spi_sdi1(1'b0), .spi_sdi2(1'b0), .spi_sdi3(1'b0),
    .spi_sdo0(sdo0), .spi_sdo1(sdo1), .spi_sdo2(sdo2), .spi_sdo3(sdo3),
    .gpio_o(gpio)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: every visible change of gpio_o consumes one expected value
  always @(posedge clk) begin
    #1;
    if (rst) last = '0;
    else if (gpio !== last) begin
      last = gpio;
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL gpio_unexpected: got %h expected no change", gpio);
      end else check("gpio_store", gpio, expq.pop_front());
    end
  end

  function automatic logic [31:0] ei(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] er(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                     input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] es(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] eb(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                     input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] eu(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] ej(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction
  function automatic logic [31:0] sx(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

  task automatic spi_frame(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d, input int nbits);
    logic [71:0] f;
    f = {c, a, d};
    @(negedge clk) cs = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sdi0 = f[71-i];
      repeat (2) @(negedge clk);
      sclk = 1'b1;
      repeat (2) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (2) @(negedge clk);
    cs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic load();
    foreach (prog[i]) spi_frame(8'h02, 32'h80 + 32'(i) * 32'd4, prog[i], 72);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    fe = 1'b0;
    ie = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_gpio", gpio, 32'h0);
  endtask

  task automatic go(input string nm, input logic [31:0] exp, input int budget);
    if (exp != 0) expq.push_back(exp);
    fe = 1'b1;
    ie = 1'b1;
    for (int i = 0; i < budget && expq.size() > 0; i++) @(negedge clk);
    if (expq.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %h expected %h", nm, gpio, exp);
      expq.delete();
    end
    repeat (exp == 0 ? 60 : 10) @(negedge clk);
    check({nm, "_final"}, gpio, exp);
    fe = 1'b0;
    ie = 1'b0;
  endtask

  initial begin
    logic [31:0] v, w, e;
    logic [11:0] imm, off;
    logic [4:0]  sh, d;
    logic [19:0] u;
    repeat (3) @(negedge clk);
    check("reset_gpio_held", gpio, 32'h0);
    check("reset_spi_mode", {30'h0, spi_mode}, 32'h0);
    check("reset_sdo", {28'h0, sdo3, sdo2, sdo1, sdo0}, 32'h0);
    rst = 1'b0;

    prog = '{32'h01E00093, 32'h80000137, 32'h00112023, 32'h00000FFF};
    do_reset();
    load();
    go("spec_prog", 32'd30, 100);

    do_reset();
    load();
    repeat (50) @(negedge clk);
    check("enables_low", gpio, 32'h0);
    fe = 1'b1;
    repeat (20) @(negedge clk);
    check("only_fetch_enable", gpio, 32'h0);
    fe = 1'b0;
    ie = 1'b1;
    repeat (20) @(negedge clk);
    check("only_ifetch_enable", gpio, 32'h0);
    ie = 1'b0;
    go("enables_raised", 32'd30, 100);

    prog = '{ei(12'd30, 5'd0, 3'd0, 5'd3, 7'h13), ei(12'd3, 5'd1, 3'd0, 5'd1, 7'h13),
             eb(13'h1FFC, 5'd3, 5'd1, 3'd1), eu(20'h80000, 5'd2, 7'h37), es(12'd0, 5'd1, 5'd2), 32'h00000FFF};
    do_reset();
    load();
    fe = 1'b1;
    ie = 1'b1;
    repeat (8) @(negedge clk);
    ie = 1'b0;
    repeat (40) @(negedge clk);
    check("freeze_gpio", gpio, 32'h0);
    go("loop_resume", 32'd30, 300);

    do_reset();
    spi_frame(8'h02, 32'h98, 32'hCAFE_0001, 72);
    spi_frame(8'h02, 32'h98, 32'hDEAD_0002, 40);
    spi_frame(8'h02, 32'h98, 32'hDEAD_0003, 71);
    spi_frame(8'h03, 32'h98, 32'hDEAD_0004, 72);
    prog = '{eu(20'h80000, 5'd2, 7'h37), ei(12'h098, 5'd0, 3'd2, 5'd1, 7'h03), es(12'd0, 5'd1, 5'd2), 32'h00000FFF};
    load();
    go("cs_abort", 32'hCAFE_0001, 100);

    for (int op = 0; op < 20; op++) begin
      v = $urandom;
      w = $urandom;
      if ($urandom_range(0, 3) == 0) w = v;
      imm = 12'($urandom_range(0, 4095));
      sh = 5'($urandom_range(0, 31));
      off = {5'($urandom_range(0, 31)), 2'b00};
      u = 20'($urandom);
      d = $urandom_range(0, 1) ? 5'd19 : 5'd3;
      prog.delete();
      prog.push_back(eu(20'((v + 32'h800) >> 12), 5'd1, 7'h37));
      prog.push_back(ei(v[11:0], 5'd1, 3'd0, 5'd1, 7'h13));
      prog.push_back(eu(20'((w + 32'h800) >> 12), 5'd2, 7'h37));
      prog.push_back(ei(w[11:0], 5'd2, 3'd0, 5'd2, 7'h13));
      case (op)
        0: begin prog.push_back(er(7'h00, 5'd2, 5'd1, 3'd0, d)); e = v + w; end
        1: begin prog.push_back(er(7'h20, 5'd2, 5'd1, 3'd0, d)); e = v - w; end
        2: begin prog.push_back(er(7'h00, 5'd2, 5'd1, 3'd7, d)); e = v & w; end
        3: begin prog.push_back(er(7'h00, 5'd2, 5'd1, 3'd6, d)); e = v | w; end
        4: begin prog.push_back(er(7'h00, 5'd2, 5'd1, 3'd4, d)); e = v ^ w; end
        5: begin prog.push_back(ei(imm, 5'd1, 3'd0, d, 7'h13)); e = v + sx(imm); end
        6: begin prog.push_back(ei(imm, 5'd1, 3'd4, d, 7'h13)); e = v ^ sx(imm); end
        7: begin prog.push_back(ei(imm, 5'd1, 3'd6, d, 7'h13)); e = v | sx(imm); end
        8: begin prog.push_back(ei(imm, 5'd1, 3'd7, d, 7'h13)); e = v & sx(imm); end
        9: begin prog.push_back(ei({7'h0, sh}, 5'd1, 3'd1, d, 7'h13)); e = v << sh; end
        10: begin prog.push_back(ei({7'h0, sh}, 5'd1, 3'd5, d, 7'h13)); e = v >> sh; end
        11: begin
          prog.push_back(es(off, 5'd1, 5'd0));
          prog.push_back(ei(off, 5'd0, 3'd2, d, 7'h03));
          e = v;
        end
        12, 13, 14: begin
          prog.push_back(ei(12'd1, 5'd0, 3'd0, d, 7'h13));
          prog.push_back(eb(13'd8, 5'd2, 5'd1, op == 12 ? 3'd4 : op == 13 ? 3'd5 : 3'd0));
          prog.push_back(ei(12'd2, 5'd0, 3'd0, d, 7'h13));
          e = op == 12 ? ($signed(v) < $signed(w) ? 32'd1 : 32'd2) :
              op == 13 ? ($signed(v) >= $signed(w) ? 32'd1 : 32'd2) : (v == w ? 32'd1 : 32'd2);
        end
        15: begin
          prog.push_back(ej(21'd8, d));
          prog.push_back(ei(12'd9, 5'd0, 3'd0, 5'd3, 7'h13));
          e = 32'h94;
        end
        16: begin
          prog.push_back(ei(12'h09F, 5'd0, 3'd0, 5'd5, 7'h13));
          prog.push_back(ei(12'd2, 5'd5, 3'd0, d, 7'h67));
          prog.push_back(ei(12'd9, 5'd0, 3'd0, 5'd3, 7'h13));
          prog.push_back(ei(12'd9, 5'd0, 3'd0, 5'd3, 7'h13));
          e = 32'h98;
        end
        17: begin prog.push_back(eu(u, d, 7'h17)); e = 32'h90 + {u, 12'h0}; end
        18: begin
          prog.push_back(eu(20'h80000, 5'd6, 7'h37));
          prog.push_back(es(12'd0, 5'd1, 5'd6));
          prog.push_back(ei(12'd4, 5'd6, 3'd2, d, 7'h03));
          e = v;
        end
        default: begin
          prog.push_back(32'h0000_000B);
          prog.push_back(ei(12'd5, 5'd1, 3'd0, 5'd0, 7'h13));
          prog.push_back(er(7'h00, 5'd2, 5'd0, 3'd0, d));
          e = w;
        end
      endcase
      prog.push_back(eu(20'h80000, 5'd4, 7'h37));
      prog.push_back(es(12'd0, 5'd3, 5'd4));
      prog.push_back(32'h00000FFF);
      do_reset();
      load();
      go($sformatf("rand_op%0d", op), e, 200);
    end

    check("end_spi_mode", {30'h0, spi_mode}, 32'h0);
    check("end_sdo", {28'h0, sdo3, sdo2, sdo1, sdo0}, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
